// File: rtl/mrd_ctrl_seq.sv
// mrd_ctrl_seq -- control sequencer for the mixed-radix DFT memory top.
//
// On each accepted frame start it factors the frame size into radix-5/4/3/2
// stages, one factor per clock, while the frame is being sunk. It then
// steps the memory through a read/write pass per stage, followed by a
// source (drain) pass.
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   sink_sop        start of an input frame (status)
//   dftpts          frame size, sampled together with sink_sop
//   sink_ongoing    sink in progress (status)
//   rd_ongoing      read pass in progress (status)
//   wr_ongoing      write pass in progress (status)
//   source_ongoing  output drain in progress (status)
//   state           memory mode: 00 sink, 01 read, 10 write, 11 source
//   current_stage   index of the active butterfly stage
//   Nf              radix per stage, entry i in bits [3i+2:3i], unused = 0
//   n_stg           number of valid stages
//   busy            frame in flight (accepted sop until source completes)
//   err             frame size not factorable; sticky until the next sop
module mrd_ctrl_seq #(
  parameter int MAX_STG = 6,
  parameter int wPTS    = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sink_sop,
  input  logic [wPTS-1:0]      dftpts,
  input  logic                 sink_ongoing,
  input  logic                 rd_ongoing,
  input  logic                 wr_ongoing,
  input  logic                 source_ongoing,
  output logic [1:0]           state,
  output logic [2:0]           current_stage,
  output logic [MAX_STG*3-1:0] Nf,
  output logic [2:0]           n_stg,
  output logic                 busy,
  output logic                 err
);

  localparam logic [2:0] MAX_STG_L = 3'(MAX_STG);

  typedef enum logic [2:0] {
    IDLE,
    SINK,
    RD,
    WR,
    SRC
  } fsm_t;

  fsm_t fsm_reg;
  fsm_t fsm_next;

  // Factorisation state
  logic [wPTS-1:0] res_reg;
  logic            fact_run_reg;
  logic            fact_done_reg;
  logic            err_reg;
  logic [2:0]      n_stg_reg;

  // Sequencing state
  logic [1:0]      state_reg;
  logic [2:0]      stage_reg;
  logic            busy_reg;

  // Seen-high / fell flags of the status input the current state waits on.
  // Only one wait state is active at a time and the pair is cleared on every
  // state entry, so a single pair serves all of them.
  logic            seen_reg;
  logic            fell_reg;

  // FSM strobes
  logic            sop_accept;
  logic            stage_clr;
  logic            stage_inc;
  logic            busy_set;
  logic            busy_clr;
  logic            flag_clr;
  logic            wait_in;

  // Radix selection
  logic [2:0]      radix;
  logic [wPTS-1:0] quot;
  logic            radix_ok;
  logic            fact_write;

  function automatic logic [1:0] encode_state(input fsm_t s);
    case (s)
      RD:      encode_state = 2'b01;
      WR:      encode_state = 2'b10;
      SRC:     encode_state = 2'b11;
      default: encode_state = 2'b00;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Radix pick: first of 5, 4, 3, 2 dividing the residue. All divisors are
  // constants, so these reduce to fixed modulo/divide-by-constant logic.
  // ---------------------------------------------------------------------
  always_comb begin
    radix    = 3'd0;
    quot     = res_reg;
    radix_ok = 1'b1;
    if (res_reg % wPTS'(5) == '0) begin
      radix = 3'd5;
      quot  = res_reg / wPTS'(5);
    end else if (res_reg[1:0] == 2'b00) begin
      radix = 3'd4;
      quot  = res_reg >> 2;
    end else if (res_reg % wPTS'(3) == '0) begin
      radix = 3'd3;
      quot  = res_reg / wPTS'(3);
    end else if (res_reg[0] == 1'b0) begin
      radix = 3'd2;
      quot  = res_reg >> 1;
    end else begin
      radix_ok = 1'b0;
    end
  end

  assign fact_write = fact_run_reg && (res_reg != wPTS'(1)) && radix_ok &&
                      (n_stg_reg != MAX_STG_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_reg       <= '0;
      fact_run_reg  <= 1'b0;
      fact_done_reg <= 1'b0;
      err_reg       <= 1'b0;
      n_stg_reg     <= 3'd0;
    end else if (sop_accept) begin
      res_reg       <= dftpts;
      n_stg_reg     <= 3'd0;
      fact_done_reg <= 1'b0;
      // Sizes 0 and 1 have no factorisation at all.
      err_reg       <= (dftpts < wPTS'(2));
      fact_run_reg  <= (dftpts >= wPTS'(2));
    end else if (fact_run_reg) begin
      if (res_reg == wPTS'(1)) begin
        fact_done_reg <= 1'b1;
        fact_run_reg  <= 1'b0;
      end else if (fact_write) begin
        res_reg   <= quot;
        n_stg_reg <= n_stg_reg + 3'd1;
      end else begin
        // Prime factor > 5 left over, or out of stage slots.
        err_reg      <= 1'b1;
        fact_run_reg <= 1'b0;
      end
    end
  end

  // One register per Nf entry; entry gi is loaded when it is the next slot.
  generate
    for (genvar gi = 0; gi < MAX_STG; gi++) begin : g_nf
      logic [2:0] nf_entry_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          nf_entry_reg <= 3'd0;
        end else if (sop_accept) begin
          nf_entry_reg <= 3'd0;
        end else if (fact_write && (n_stg_reg == 3'(gi))) begin
          nf_entry_reg <= radix;
        end
      end

      assign Nf[gi*3 +: 3] = nf_entry_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg <= IDLE;
    end else begin
      fsm_reg <= fsm_next;
    end
  end

  // Status input the current state is waiting to see rise and fall.
  always_comb begin
    wait_in = 1'b0;
    case (fsm_reg)
      SINK:    wait_in = sink_ongoing;
      RD:      wait_in = rd_ongoing;
      WR:      wait_in = wr_ongoing;
      SRC:     wait_in = source_ongoing;
      default: wait_in = 1'b0;
    endcase
  end

  // Transitions act on the registered fell flag, which gives one cycle of
  // reaction latency after the fall is sampled.
  always_comb begin
    fsm_next   = fsm_reg;
    sop_accept = 1'b0;
    stage_clr  = 1'b0;
    stage_inc  = 1'b0;
    busy_set   = 1'b0;
    busy_clr   = 1'b0;
    case (fsm_reg)
      IDLE: begin
        if (sink_sop) begin
          sop_accept = 1'b1;
          busy_set   = 1'b1;
          fsm_next   = SINK;
        end
      end
      SINK: begin
        // A new sop always wins, even against a completing sink.
        if (sink_sop) begin
          sop_accept = 1'b1;
          busy_set   = 1'b1;
        end else if (fell_reg && err_reg) begin
          busy_clr = 1'b1;
          fsm_next = IDLE;
        end else if (fell_reg && fact_done_reg) begin
          stage_clr = 1'b1;
          fsm_next  = RD;
        end
      end
      RD: begin
        if (fell_reg) begin
          fsm_next = WR;
        end
      end
      WR: begin
        if (fell_reg) begin
          if (stage_reg == n_stg_reg - 3'd1) begin
            fsm_next = SRC;
          end else begin
            stage_inc = 1'b1;
            fsm_next  = RD;
          end
        end
      end
      SRC: begin
        if (fell_reg) begin
          busy_clr = 1'b1;
          fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign flag_clr = sop_accept || (fsm_next != fsm_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_reg <= 1'b0;
      fell_reg <= 1'b0;
    end else if (flag_clr) begin
      seen_reg <= 1'b0;
      fell_reg <= 1'b0;
    end else begin
      seen_reg <= seen_reg | wait_in;
      // Uses the old seen flag: a low in the cycle the flag gets set is not
      // a completion.
      fell_reg <= fell_reg | (seen_reg & ~wait_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= 2'b00;
      stage_reg <= 3'd0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= encode_state(fsm_next);
      if (stage_clr) begin
        stage_reg <= 3'd0;
      end else if (stage_inc) begin
        stage_reg <= stage_reg + 3'd1;
      end
      if (busy_set) begin
        busy_reg <= 1'b1;
      end else if (busy_clr) begin
        busy_reg <= 1'b0;
      end
    end
  end

  assign state         = state_reg;
  assign current_stage = stage_reg;
  assign n_stg         = n_stg_reg;
  assign busy          = busy_reg;
  assign err           = err_reg;

endmodule
